timer_multi_ch: RTL and testbench
=================================

Name: timer_multi_ch

Overview:
- N-channel, parametrised-width programmable timer with an APB-style slave interface. It generalises the existing single 8-bit up/down timer (registers TDR/TCR/TSR) to NUM_CH channels of CNT_W bits.
- New features: auto-reload mode, per-channel interrupt enables, a readable live count, and per-channel plus combined interrupt outputs.
- Sits on the peripheral bus and feeds the interrupt handler.

Parameters:
- NUM_CH, 2, number of independent timer channels (1..32)
- CNT_W, 8, counter and bus data width in bits (8..32)
- ADDR_W, 8, bus address width; channel c occupies byte offsets c*8 .. c*8+4

Ports:
- pclk  in  1  system clock; all logic on rising edge
- presetn  in  1  asynchronous active-low reset
- psel  in  1  APB select
- penable  in  1  APB access phase
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_W  byte address
- pwdata  in  CNT_W  write data
- prdata  out  CNT_W  read data; valid in access phase
- pready  out  1  tied 1 (zero wait states)
- pslverr  out  1  error response for an unmapped address or a write to a read-only register
- irq  out  NUM_CH  per-channel interrupt, irq[c] = |(TSR[c] & TIER[c])
- irq_any  out  1  OR of irq

Behaviour:
- Register map per channel, base c*8:
  - +0 TDR (rw, reload/load value)
  - +1 TCR (rw)
  - +2 TSR (r / w0c)
  - +3 TIER (rw, bit0 OVF enable, bit1 UDF enable)
  - +4 TCNT (ro)
  - Offsets +5..+7 and channel index >= NUM_CH are unmapped: read 0, pslverr=1, no state change.
- TCR bits:
  - [7] LOAD
  - [5] DIR (1 down, 0 up)
  - [4] EN
  - [3] AR (auto-reload)
  - [1:0] CKS: 00 = pclk/2, 01 = /4, 10 = /8, 11 = /16
  - Other bits read 0.
- Bus timing:
  - A write commits on the pclk edge with psel & penable & pwrite.
  - A read drives prdata combinationally during psel & penable & !pwrite, and 0 otherwise.
- Reset values: all registers, counters and prescalers 0; prdata=0, pslverr=0, irq=0, irq_any=0, pready=1.
- Prescaler:
  - Per-channel free-running divider; it is held at 0 while EN=0 or LOAD=1.
  - It produces a 1-cycle tick every 2^(CKS+1) pclk.
  - The first tick comes 2^(CKS+1) cycles after EN rises.
- Counter priority per edge:
  - LOAD=1: TCNT <= TDR. LOAD overrides EN.
  - Else if EN and tick: TCNT +/- 1 per DIR.
- Underflow (DIR=1, TCNT==0 at a tick):
  - TSR[1] set.
  - TCNT <= AR ? TDR : all-ones.
- Overflow (DIR=0, TCNT==all-ones at a tick):
  - TSR[0] set.
  - TCNT <= AR ? TDR : 0.
- TSR flags:
  - Sticky.
  - Software clears a flag by writing 0 to its bit; writing 1 has no effect.
  - A hardware set and a software clear in the same cycle: the set wins.
- Writing TDR while running does not change TCNT until the next LOAD or reload.
- Changing CKS mid-count does not reset the prescaler; the new divisor applies from the next wrap.
- irq and irq_any are combinational from the registers.
- An asynchronous reset mid-count immediately returns all state to reset values.

Test Plan:
- Countdown, ch0: TDR=0xFF, TSR=0, TCR=0x80 then TCR=0x30 (down, /2) -> TSR=0x00 read at 500 pclk after enable; TSR=0x02 at 512 pclk; write TSR=0x00 -> reads 0x00.
- Count-up with auto-reload, ch1: TDR=0xF0, TCR=0x80, then TCR=0x19 (up, AR, /4), TIER=0x01 -> TSR[0] set and irq[1]=1 after 16*4=64 pclk; TCNT then reads 0xF0; a second overflow arrives 64 pclk later.
- Simultaneous clear and set: software writes TSR=0 on the same edge an underflow occurs -> TSR[1] remains 1 and irq follows TIER.
- LOAD priority: TCR=0x90 (LOAD+EN) held for 100 pclk -> TCNT stays equal to TDR with no flags; clearing LOAD starts counting 2 pclk later.
- Error response: read offset +5 and write TCNT (+4) -> pslverr=1, prdata=0, no register changes; access to channel index NUM_CH -> pslverr=1.
- Reset mid-operation: assert presetn=0 while ch0 counts with irq asserted -> immediately TCNT=0, TSR=0, irq=0, irq_any=0; counting resumes only after reprogramming.

Source files
------------

// File: rtl/timer_multi_ch.sv
// NUM_CH-channel programmable up/down timer with APB-style register access.
// Per channel: TDR reload value, TCR control, TSR sticky flags, TIER irq enables, TCNT live count.
module timer_multi_ch #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [CNT_W-1:0]  pwdata,
  output logic [CNT_W-1:0]  prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  logic [2:0]       w_off;
  logic [31:0]      w_ch;
  logic             w_access;
  logic             w_mapped;
  logic             w_wr;
  logic             w_rd;
  logic [CNT_W-1:0] w_rdata;

  logic [CNT_W-1:0] w_tdr  [NUM_CH];
  logic [CNT_W-1:0] w_cnt  [NUM_CH];
  logic [7:0]       w_tcr  [NUM_CH];
  logic [1:0]       w_tsr  [NUM_CH];
  logic [1:0]       w_tier [NUM_CH];

  assign w_off    = paddr[2:0];
  assign w_ch     = 32'(paddr[ADDR_W-1:3]);
  assign w_access = psel & penable;
  assign w_mapped = (w_ch < NUM_CH) && (w_off <= 3'd4);
  // TCNT is read-only, so a write to it is an error and changes nothing.
  assign w_wr     = w_access & pwrite & w_mapped & (w_off != 3'd4);
  assign w_rd     = w_access & ~pwrite & w_mapped;
  assign pslverr  = w_access & (~w_mapped | (pwrite & (w_off == 3'd4)));
  assign pready   = 1'b1;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] r_tdr;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_tcr;
    logic [1:0]       r_tsr;
    logic [1:0]       r_tier;
    logic [3:0]       r_psc;
    logic             w_sel;
    logic             w_load;
    logic             w_dir;
    logic             w_en;
    logic             w_ar;
    logic             w_tick;
    logic             w_udf;
    logic             w_ovf;
    logic [3:0]       w_mask;
    logic [CNT_W-1:0] w_cnt_d;
    logic [1:0]       w_tsr_d;

    assign w_sel  = w_wr && (w_ch == 32'(c));
    assign w_load = r_tcr[7];
    assign w_dir  = r_tcr[5];
    assign w_en   = r_tcr[4];
    assign w_ar   = r_tcr[3];

    always_comb begin
      w_mask = 4'hF;
      case (r_tcr[1:0])
        2'd0:    w_mask = 4'h1;
        2'd1:    w_mask = 4'h3;
        2'd2:    w_mask = 4'h7;
        default: w_mask = 4'hF;
      endcase
    end

    // Masked compare on a free-running count lets CKS change without a prescaler reset.
    assign w_tick = w_en & ~w_load & ((r_psc & w_mask) == w_mask);
    assign w_udf  = w_tick & w_dir & (r_cnt == '0);
    assign w_ovf  = w_tick & ~w_dir & (r_cnt == '1);

    always_comb begin
      w_cnt_d = r_cnt;
      if (w_load) begin
        w_cnt_d = r_tdr;
      end else if (w_udf || w_ovf) begin
        w_cnt_d = w_ar ? r_tdr : (w_udf ? '1 : '0);
      end else if (w_tick) begin
        w_cnt_d = w_dir ? r_cnt - CNT_W'(1) : r_cnt + CNT_W'(1);
      end
      w_tsr_d = r_tsr;
      if (w_sel && (w_off == 3'd2)) begin
        w_tsr_d = r_tsr & pwdata[1:0];
      end
      // Hardware set is applied last so it beats a same-cycle software clear.
      w_tsr_d = w_tsr_d | {w_udf, w_ovf};
    end

    always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
        r_tdr  <= '0;
        r_cnt  <= '0;
        r_tcr  <= '0;
        r_tsr  <= '0;
        r_tier <= '0;
        r_psc  <= '0;
      end else begin
        if (w_sel && (w_off == 3'd0)) r_tdr  <= pwdata;
        if (w_sel && (w_off == 3'd1)) r_tcr  <= pwdata[7:0] & 8'hBB;
        if (w_sel && (w_off == 3'd3)) r_tier <= pwdata[1:0];
        r_tsr <= w_tsr_d;
        r_cnt <= w_cnt_d;
        r_psc <= (w_en && !w_load) ? r_psc + 4'd1 : 4'd0;
      end
    end

    assign w_tdr[c]  = r_tdr;
    assign w_cnt[c]  = r_cnt;
    assign w_tcr[c]  = r_tcr;
    assign w_tsr[c]  = r_tsr;
    assign w_tier[c] = r_tier;
    assign irq[c]    = |(r_tsr & r_tier);
  end

  always_comb begin
    w_rdata = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (w_ch == c) begin
        case (w_off)
          3'd0:    w_rdata = w_tdr[c];
          3'd1:    w_rdata = CNT_W'(w_tcr[c]);
          3'd2:    w_rdata = CNT_W'(w_tsr[c]);
          3'd3:    w_rdata = CNT_W'(w_tier[c]);
          3'd4:    w_rdata = w_cnt[c];
          default: w_rdata = '0;
        endcase
      end
    end
  end

  assign prdata  = w_rd ? w_rdata : '0;
  assign irq_any = |irq;

endmodule

// File: tb/tb_timer_multi_ch.sv
// Directed bench for timer_multi_ch (2 channels, 8-bit): bus-driven scenarios with
// cycle-exact expectations counted from the edge that commits each enabling write.
module tb_timer_multi_ch;

  logic       pclk;
  logic       presetn;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic [1:0] irq;
  logic       irq_any;

  int unsigned n_vec;
  int unsigned n_err;
  int unsigned cyc;
  int unsigned t0;
  logic [7:0]  rd;
  logic        er;

  timer_multi_ch #(
    .NUM_CH (2),
    .CNT_W  (8),
    .ADDR_W (8)
  ) u_dut (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .irq     (irq),
    .irq_any (irq_any)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    cyc++;
  endtask

  // Write commits on the third edge; on return cyc is that commit edge.
  task automatic apb_wr(input logic [7:0] a, input logic [7:0] d, output logic err);
    tick();
    #1 psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    tick();
    #1 penable = 1'b1;
    #2 err = pslverr;
    tick();
    #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    logic e;
    apb_wr(a, d, e);
  endtask

  // Read samples in the access phase that follows the second edge.
  task automatic apb_rd(input logic [7:0] a, output logic [7:0] data, output logic err);
    tick();
    #1 psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    tick();
    #1 penable = 1'b1;
    #2 data = prdata; err = pslverr;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Sample register a just after edge n.
  task automatic read_at(input logic [7:0] a, input int unsigned n, output logic [7:0] data);
    logic e;
    if (cyc + 2 > n) check_eq("sched", cyc, n - 2);
    while (cyc + 2 < n) tick();
    apb_rd(a, data, e);
  endtask

  task automatic wait_to(input int unsigned n);
    while (cyc < n) tick();
    #1;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    #2;
    check_eq("rst_pready", pready, 1);
    check_eq("rst_irq", irq, 0);
    check_eq("rst_irq_any", irq_any, 0);
    check_eq("rst_prdata", prdata, 0);
    check_eq("rst_pslverr", pslverr, 0);
    tick(); tick();
    #1 presetn = 1'b1;
    apb_rd(8'h0C, rd, er); check_eq("rst_tcnt1", rd, 8'h00);
    apb_rd(8'h02, rd, er); check_eq("rst_tsr0", rd, 8'h00);

    // Countdown on ch0 from 0xFF at pclk/2: underflow on tick 256 = edge 512.
    wr(8'h00, 8'hFF); wr(8'h02, 8'h00); wr(8'h01, 8'h80); wr(8'h01, 8'h30);
    t0 = cyc;
    read_at(8'h02, t0 + 500, rd); check_eq("dn_tsr_500", rd, 8'h00);
    read_at(8'h04, t0 + 503, rd); check_eq("dn_tcnt_503", rd, 8'h04);
    read_at(8'h02, t0 + 512, rd); check_eq("dn_tsr_512", rd, 8'h02);
    check_eq("dn_irq_masked", irq, 0);
    read_at(8'h04, t0 + 515, rd); check_eq("dn_wrap_ff", rd, 8'hFE);
    wr(8'h02, 8'h00);
    apb_rd(8'h02, rd, er); check_eq("dn_tsr_clr", rd, 8'h00);
    wr(8'h01, 8'h00);

    // Up-count with auto-reload on ch1 from 0xF0 at pclk/4: overflow every 64 edges.
    wr(8'h08, 8'hF0); wr(8'h09, 8'h80); wr(8'h09, 8'h19);
    t0 = cyc;
    wr(8'h0B, 8'h01);
    read_at(8'h0A, t0 + 63, rd); check_eq("up_tsr_63", rd, 8'h00);
    wait_to(t0 + 64);
    check_eq("up_irq_64", irq, 2'b10);
    check_eq("up_irq_any_64", irq_any, 1);
    read_at(8'h0C, t0 + 66, rd); check_eq("up_reload", rd, 8'hF0);
    wr(8'h0A, 8'h00);
    read_at(8'h0A, t0 + 127, rd); check_eq("up_tsr_127", rd, 8'h00);
    wait_to(t0 + 128);
    check_eq("up_irq_128", irq, 2'b10);
    wr(8'h09, 8'h00); wr(8'h0A, 8'h00); wr(8'h0B, 8'h00);

    // Underflow on edge t0+6 coincides with a software write of TSR=0.
    wr(8'h00, 8'h02); wr(8'h01, 8'h80); wr(8'h01, 8'h30);
    t0 = cyc;
    wr(8'h03, 8'h02);
    wr(8'h02, 8'h00);
    read_at(8'h02, t0 + 8, rd); check_eq("race_tsr", rd, 8'h02);
    check_eq("race_irq", irq, 2'b01);
    check_eq("race_irq_any", irq_any, 1);
    wr(8'h03, 8'h00);
    #1 check_eq("race_irq_off", irq, 0);
    wr(8'h01, 8'h00); wr(8'h02, 8'h00);

    // LOAD held with EN on ch1 pins TCNT; counting begins 2 edges after release.
    wr(8'h08, 8'h55); wr(8'h09, 8'h90);
    t0 = cyc;
    read_at(8'h0C, t0 + 100, rd); check_eq("ld_hold_tcnt", rd, 8'h55);
    read_at(8'h0A, t0 + 102, rd); check_eq("ld_hold_tsr", rd, 8'h00);
    wr(8'h09, 8'h10);
    t0 = cyc;
    read_at(8'h0C, t0 + 2, rd); check_eq("ld_first_tick", rd, 8'h56);
    read_at(8'h0C, t0 + 5, rd); check_eq("ld_second_tick", rd, 8'h57);
    wr(8'h09, 8'h00);

    // Error responses; ch0 parked at a known count.
    wr(8'h00, 8'h3C); wr(8'h01, 8'h80); wr(8'h01, 8'h00);
    apb_wr(8'h04, 8'h77, er); check_eq("err_wr_tcnt", er, 1);
    apb_rd(8'h04, rd, er);    check_eq("err_tcnt_kept", rd, 8'h3C);
    check_eq("err_tcnt_rd_ok", er, 0);
    apb_rd(8'h05, rd, er);    check_eq("err_rd5_flag", er, 1);
    check_eq("err_rd5_data", rd, 8'h00);
    apb_wr(8'h07, 8'hAA, er); check_eq("err_wr7_flag", er, 1);
    apb_rd(8'h03, rd, er);    check_eq("err_tier_kept", rd, 8'h00);
    apb_rd(8'h10, rd, er);    check_eq("err_ch2_rd_flag", er, 1);
    check_eq("err_ch2_rd_data", rd, 8'h00);
    apb_wr(8'h10, 8'h99, er); check_eq("err_ch2_wr_flag", er, 1);
    apb_rd(8'h00, rd, er);    check_eq("err_tdr_kept", rd, 8'h3C);
    apb_wr(8'h01, 8'hFF, er); check_eq("tcr_wr_ok", er, 0);
    apb_rd(8'h01, rd, er);    check_eq("tcr_rsvd_zero", rd, 8'hBB);
    wr(8'h01, 8'h00);

    // Asynchronous reset while ch0 has a pending underflow interrupt.
    wr(8'h00, 8'h03); wr(8'h03, 8'h02); wr(8'h01, 8'h80); wr(8'h01, 8'h30);
    t0 = cyc;
    wait_to(t0 + 10);
    check_eq("pre_rst_irq", irq, 2'b01);
    #2 presetn = 1'b0;
    #1 check_eq("arst_irq", irq, 0);
    check_eq("arst_irq_any", irq_any, 0);
    tick(); tick();
    #1 presetn = 1'b1;
    apb_rd(8'h04, rd, er); check_eq("arst_tcnt", rd, 8'h00);
    apb_rd(8'h02, rd, er); check_eq("arst_tsr", rd, 8'h00);
    apb_rd(8'h01, rd, er); check_eq("arst_tcr", rd, 8'h00);
    apb_rd(8'h00, rd, er); check_eq("arst_tdr", rd, 8'h00);
    repeat (20) tick();
    apb_rd(8'h04, rd, er); check_eq("arst_idle", rd, 8'h00);
    wr(8'h00, 8'h05); wr(8'h01, 8'h80); wr(8'h01, 8'h30);
    t0 = cyc;
    read_at(8'h04, t0 + 4, rd); check_eq("arst_resume", rd, 8'h03);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
